dmem_arbiter: RTL and testbench

Two-requester access controller placed in front of the word-only data memory, which has an asynchronous read, a synchronous write, and ignores writes to unaligned addresses. It arbitrates between the CPU load/store port (A) and a debug/DMA port (B). It executes RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) by sign/zero-extending loads and sequencing sub-word stores as read-modify-write. It always presents word-aligned addresses to the memory and flags misaligned or illegal requests without touching memory.

---
 rtl/dmem_arbiter.sv | 90 +++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port RV32I load/store controller in front of a word-only data memory
module dmem_arbiter #(
    parameter bit RR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [2:0]  a_funct3,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [2:0]  b_funct3,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2, DONE = 2'd3;
    logic [1:0]  st;
    logic        last_b, own_b, we_q, idle, align, legal, sub, fin;
    logic [31:0] addr_q, wd_q, merge_q, lane, mask, ld_res;
    logic [2:0]  f3_q;
    logic [4:0]  sh;
    assign idle  = st == IDLE && !rst;
    assign a_gnt = idle && a_req && (!b_req || !RR || last_b);
    assign b_gnt = idle && b_req && !a_gnt;
    // f3[1:0]==3 never aligns, which also rejects funct3 011/111
    assign align = f3_q[1] ? (!f3_q[0] && addr_q[1:0] == 2'b00) : (!f3_q[0] || !addr_q[0]);
    assign legal = align && (we_q ? !f3_q[2] : !(f3_q[2] && f3_q[1]));
    assign sub   = we_q && legal && f3_q[1:0] != 2'd2;
    assign fin   = (st == ACCESS && !sub) || st == MERGE;
    assign sh    = f3_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
    assign lane  = mem_rd >> sh;
    assign mask  = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign ld_res = f3_q[1] ? mem_rd :
                    f3_q[0] ? {{16{lane[15] && !f3_q[2]}}, lane[15:0]} :
                              {{24{lane[7] && !f3_q[2]}}, lane[7:0]};
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_wd   = st == MERGE ? (merge_q & ~mask) | ((wd_q << sh) & mask) : wd_q;
    assign mem_we   = !rst && legal && we_q && (st == MERGE || (st == ACCESS && f3_q[1:0] == 2'd2));
    assign a_rvalid = !rst && st == DONE && !own_b;
    assign b_rvalid = !rst && st == DONE && own_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            last_b  <= 1'b1;
            a_rdata <= '0;
            b_rdata <= '0;
            a_err   <= 1'b0;
            b_err   <= 1'b0;
        end else begin
            st <= st == IDLE   ? (a_gnt || b_gnt ? ACCESS : IDLE) :
                  st == ACCESS ? (sub ? MERGE : DONE) :
                  st == MERGE  ? DONE : IDLE;
            if (a_gnt || b_gnt) begin
                own_b  <= b_gnt;
                last_b <= b_gnt;
                we_q   <= b_gnt ? b_we : a_we;
                addr_q <= b_gnt ? b_addr : a_addr;
                f3_q   <= b_gnt ? b_funct3 : a_funct3;
                wd_q   <= b_gnt ? b_wdata : a_wdata;
            end
            if (st == ACCESS)
                merge_q <= mem_rd;
            // results land on the edge into DONE so they are valid alongside rvalid
            if (fin && own_b) begin
                b_err <= !legal;
                if (!legal || !we_q)
                    b_rdata <= legal ? ld_res : '0;
            end
            if (fin && !own_b) begin
                a_err <= !legal;
                if (!legal || !we_q)
                    a_rdata <= legal ? ld_res : '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, corner sequences and random traffic against a transaction-level model
module tb_dmem_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req, a_we, a_gnt, a_rvalid, a_err, b_req, b_we, b_gnt, b_rvalid, b_err, mem_we;
    logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata, mem_addr, mem_wd, mem_rd;
    logic [2:0]  a_funct3, b_funct3;
    logic        z_a_req, z_b_req, z_a_gnt, z_b_gnt, z_a_rvalid, z_b_rvalid, z_a_err, z_b_err, z_mem_we;
    logic [31:0] z_a_rdata, z_b_rdata, z_mem_addr, z_mem_wd;

    dmem_arbiter #(.RR(1)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_funct3(a_funct3), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_funct3(b_funct3), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.RR(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .a_req(z_a_req), .a_we(1'b0), .a_addr(32'h0), .a_funct3(3'b010), .a_wdata(32'h0),
        .a_gnt(z_a_gnt), .a_rvalid(z_a_rvalid), .a_rdata(z_a_rdata), .a_err(z_a_err),
        .b_req(z_b_req), .b_we(1'b0), .b_addr(32'h0), .b_funct3(3'b010), .b_wdata(32'h0),
        .b_gnt(z_b_gnt), .b_rvalid(z_b_rvalid), .b_rdata(z_b_rdata), .b_err(z_b_err),
        .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wd(z_mem_wd), .mem_rd(32'h0)
    );

    // word memory: async read, sync write, unaligned writes ignored; preload port for the bench
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    assign mem_rd = mem[mem_addr[7:2]];
    always @(posedge clk)
        if (mem_we && mem_addr[1:0] == 2'b00) mem[mem_addr[7:2]] <= mem_wd;
        else if (pl_en) mem[pl_idx] <= pl_val;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, fails = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic legal_m(input logic we, input logic [31:0] ad, input logic [2:0] f);
        if (we ? f > 3'd2 : (f == 3'd3 || f > 3'd5)) return 1'b0;
        return ad % nbytes(f) == 0;
    endfunction

    function automatic logic [31:0] ld_m(input logic [31:0] w, input logic [31:0] ad, input logic [2:0] f);
        int v;
        v = int'(w >> (8 * (ad % 4)));
        case (f)
            3'd0: begin v = v & 255; return 32'(v >= 128 ? v - 256 : v); end
            3'd1: begin v = v & 65535; return 32'(v >= 32768 ? v - 65536 : v); end
            3'd4: return 32'(v & 255);
            3'd5: return 32'(v & 65535);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] st_m(input logic [31:0] w, input logic [31:0] ad, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] r;
        int o;
        r = w;
        o = int'(ad % 4);
        for (int i = 0; i < nbytes(f); i++) r[8 * (o + i) +: 8] = d[8 * i +: 8];
        return r;
    endfunction

    // transaction-level reference: one operation in flight, result applied at completion
    typedef struct { logic p; logic we; logic [31:0] ad; logic [2:0] f; logic [31:0] wd; int t; } txn_t;
    txn_t        cur;
    logic        busy = 1'b0, prev_b = 1'b1;
    int          nwe = 0, glen = 0;
    logic        glog [256];
    logic [31:0] sh_mem [64];
    logic [31:0] rd_m [2];
    always @(negedge clk) begin
        logic ea, eb, lg, p;
        int idx;
        if (pl_en) sh_mem[pl_idx] = pl_val;
        if (rst) begin
            chk("reset_quiet", {27'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we}, 32'd0);
            busy = 1'b0;
            prev_b = 1'b1;
            rd_m[0] = '0;
            rd_m[1] = '0;
        end else begin
            ea = !busy && a_req && (!b_req || prev_b);
            eb = !busy && b_req && !ea;
            chk("grant", {30'd0, a_gnt, b_gnt}, {30'd0, ea, eb});
            if (mem_we) begin
                nwe++;
                chk("mem_addr", mem_addr, {cur.ad[31:2], 2'b00});
            end
            if (a_rvalid || b_rvalid) begin
                p   = cur.p;
                idx = int'(cur.ad[7:2]);
                lg  = legal_m(cur.we, cur.ad, cur.f);
                chk("rvalid_busy", {31'd0, busy}, 32'd1);
                chk("rvalid_owner", {30'd0, a_rvalid, b_rvalid}, p ? 32'd1 : 32'd2);
                chk("latency", 32'(cyc - cur.t), (cur.we && lg && nbytes(cur.f) < 4) ? 32'd3 : 32'd2);
                chk("write_count", 32'(nwe), (cur.we && lg) ? 32'd1 : 32'd0);
                if (!lg) rd_m[p] = '0;
                else if (!cur.we) rd_m[p] = ld_m(sh_mem[idx], cur.ad, cur.f);
                else sh_mem[idx] = st_m(sh_mem[idx], cur.ad, cur.wd, cur.f);
                chk("rdata", p ? b_rdata : a_rdata, rd_m[p]);
                chk("err", {31'd0, p ? b_err : a_err}, {31'd0, !lg});
                chk("mem_word", mem[idx], sh_mem[idx]);
                busy = 1'b0;
            end
            if (busy && cyc - cur.t > 4) begin
                chk("completion_timeout", 32'(cyc - cur.t), 32'd3);
                busy = 1'b0;
            end
            if (a_gnt || b_gnt) begin
                cur = '{b_gnt, b_gnt ? b_we : a_we, b_gnt ? b_addr : a_addr, b_gnt ? b_funct3 : a_funct3,
                        b_gnt ? b_wdata : a_wdata, cyc};
                busy = 1'b1;
                nwe = 0;
                prev_b = b_gnt;
                glog[glen % 256] = b_gnt;
                glen++;
            end
        end
    end

    task automatic preload(input int i, input logic [31:0] v);
        pl_idx = 6'(i);
        pl_val = v;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic op(input logic p, input logic we, input logic [31:0] ad, input logic [2:0] f,
                      input logic [31:0] wd, output int g);
        if (p) begin b_req = 1; b_we = we; b_addr = ad; b_funct3 = f; b_wdata = wd; end
        else begin a_req = 1; a_we = we; a_addr = ad; a_funct3 = f; a_wdata = wd; end
        g = -1;
        for (int n = 0; n < 40 && g < 0; n++) begin
            @(negedge clk);
            if (p ? b_gnt : a_gnt) g = cyc;
        end
        if (g < 0) chk("grant_timeout", 32'(p), 32'hFFFF_FFFF);
        @(posedge clk); #1;
        if (p) b_req = 0; else a_req = 0;
    endtask

    task automatic wait_rv(input logic p, output logic [31:0] rd, output logic er, output int t);
        t = -1;
        rd = 'x;
        er = 1'bx;
        for (int n = 0; n < 10 && t < 0; n++) begin
            @(negedge clk);
            if (p ? b_rvalid : a_rvalid) begin
                rd = p ? b_rdata : a_rdata;
                er = p ? b_err : a_err;
                t = cyc;
            end
        end
        if (t < 0) chk("rvalid_timeout", 32'(p), 32'hFFFF_FFFF);
        @(posedge clk); #1;
    endtask

    task automatic rnd_op(input logic p);
        logic        we;
        logic [2:0]  f;
        logic [31:0] ad;
        int          g;
        we = 1'($urandom_range(0, 1));
        f  = 3'($urandom_range(0, 7));
        ad = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) ad = ad & ~32'(nbytes(f) - 1);
        if (we && $urandom_range(0, 3) != 0) f[2] = 1'b0;
        op(p, we, ad, f, $urandom, g);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    endtask

    typedef struct { logic p; logic we; logic [31:0] ad; logic [2:0] f; logic [31:0] wd;
                     logic [31:0] rd; logic er; int lat; } vec_t;
    vec_t tv [14];

    initial begin
        int g, g2, t, base, za, zb;
        logic [31:0] rd;
        logic er;
        {a_req, a_we, a_addr, a_funct3, a_wdata} = '0;
        {b_req, b_we, b_addr, b_funct3, b_wdata} = '0;
        z_a_req = 0;
        z_b_req = 0;
        tv[0]  = '{0, 0, 32'h12, 3'd0, 32'h0,        32'hFFFF_FFFF, 0, 2};
        tv[1]  = '{0, 0, 32'h13, 3'd4, 32'h0,        32'h0000_0080, 0, 2};
        tv[2]  = '{0, 0, 32'h12, 3'd1, 32'h0,        32'hFFFF_80FF, 0, 2};
        tv[3]  = '{0, 0, 32'h10, 3'd5, 32'h0,        32'h0000_7F01, 0, 2};
        tv[4]  = '{1, 0, 32'h10, 3'd2, 32'h0,        32'h80FF_7F01, 0, 2};
        tv[5]  = '{1, 0, 32'h11, 3'd0, 32'h0,        32'h0000_007F, 0, 2};
        tv[6]  = '{1, 1, 32'h21, 3'd0, 32'h1234_56AB, 32'h0000_007F, 0, 3};
        tv[7]  = '{1, 0, 32'h20, 3'd2, 32'h0,        32'h1122_AB44, 0, 2};
        tv[8]  = '{0, 1, 32'h06, 3'd2, 32'h1234_5678, 32'h0,        1, 2};
        tv[9]  = '{0, 0, 32'h01, 3'd1, 32'h0,        32'h0,         1, 2};
        tv[10] = '{0, 0, 32'h10, 3'd3, 32'h0,        32'h0,         1, 2};
        tv[11] = '{0, 1, 32'h22, 3'd1, 32'h9999_5566, 32'h0,        0, 3};
        tv[12] = '{1, 1, 32'h20, 3'd3, 32'h0,        32'h0,         1, 2};
        tv[13] = '{0, 0, 32'h22, 3'd5, 32'h0,        32'h0000_5566, 0, 2};

        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        rst = 0;
        @(negedge clk);
        chk("reset_rdata", {a_rdata ^ b_rdata, 32'(a_rdata | b_rdata)}, 32'd0);
        chk("reset_flags", {28'd0, a_err, b_err, a_rvalid, mem_we}, 32'd0);
        @(posedge clk); #1;

        preload(4, 32'h80FF_7F01);
        preload(8, 32'h1122_3344);
        preload(1, 32'h0BAD_F00D);
        for (int i = 0; i < 14; i++) begin
            op(tv[i].p, tv[i].we, tv[i].ad, tv[i].f, tv[i].wd, g);
            wait_rv(tv[i].p, rd, er, t);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tv[i].er});
            chk($sformatf("vec%0d_latency", i), 32'(t - g), 32'(tv[i].lat));
        end
        chk("misaligned_sw_untouched", mem[1], 32'h0BAD_F00D);
        chk("sh_merged_word", mem[8], 32'h5566_AB44);

        op(0, 1, 32'h40, 3'd2, 32'hDEAD_BEEF, g);
        op(0, 0, 32'h40, 3'd2, 32'h0, g2);
        chk("b2b_grant_gap", 32'(g2 - g), 32'd3);
        wait_rv(0, rd, er, t);
        chk("b2b_readback", rd, 32'hDEAD_BEEF);

        // abort a half-word store in its write cycle
        preload(12, 32'h0102_0304);
        op(0, 1, 32'h32, 3'd1, 32'h0000_BEEF, g);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("merge_rst_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_outputs", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err}, 32'd0);
        chk("post_rst_rdata", a_rdata | b_rdata, 32'd0);
        chk("merge_rst_mem", mem[12], 32'h0102_0304);
        @(posedge clk); #1;

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        base = glen;
        fork
            begin int ga; op(0, 0, 32'h10, 3'd2, 0, ga); op(0, 0, 32'h14, 3'd2, 0, ga); end
            begin int gb; op(1, 0, 32'h20, 3'd2, 0, gb); op(1, 0, 32'h24, 3'd2, 0, gb); end
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("rr_count", 32'(glen - base), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_order%0d", i), {31'd0, glog[(base + i) % 256]}, 32'(i % 2));

        z_a_req = 1;
        z_b_req = 1;
        za = 0;
        zb = 0;
        repeat (12) begin
            @(negedge clk);
            za += int'(z_a_gnt);
            zb += int'(z_b_gnt);
        end
        chk("fixed_a_grants", 32'(za), 32'd4);
        chk("fixed_b_grants", 32'(zb), 32'd0);
        @(posedge clk); #1;
        z_a_req = 0;
        zb = 0;
        for (int n = 0; n < 5 && zb == 0; n++) begin
            @(negedge clk);
            zb = int'(z_b_gnt);
        end
        chk("fixed_b_alone", 32'(zb), 32'd1);
        @(posedge clk); #1;
        z_b_req = 0;

        fork
            for (int i = 0; i < 60; i++) rnd_op(0);
            for (int i = 0; i < 60; i++) rnd_op(1);
        join
        repeat (6) begin @(posedge clk); #1; end
        chk("drain_idle", {31'd0, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
